// File: rtl/stage3_pkg.sv
// Shared definitions for the execute stage:
// ALU opcodes, default widths and the MEM/WB control bundle.
package stage3_pkg;

    localparam int DEF_W      = 32;
    localparam int DEF_RW     = 6;
    localparam int DEF_SQUASH = 2;

    typedef enum logic [2:0] {
        ALUOP_PASSA = 3'b000,
        ALUOP_ADD   = 3'b001,
        ALUOP_SUB   = 3'b010,
        ALUOP_NEG   = 3'b011,
        ALUOP_PASSB = 3'b100
    } aluop_e;

    typedef struct packed {
        logic regw;
        logic wai;
        logic memw;
        logic memr;
    } ctrl_t;

endpackage

// File: rtl/stage3_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage.
// The slave side is the stage; the master side is decode/memory.
interface stage3_if #(
    parameter int W  = stage3_pkg::DEF_W,
    parameter int RW = stage3_pkg::DEF_RW
);
    logic          in_valid;
    logic [W-1:0]  in_imm;
    logic [RW-1:0] in_rd;
    logic [W-1:0]  in_rd1;
    logic [W-1:0]  in_rd2;
    logic [W-1:0]  in_PC;
    logic          in_brz;
    logic          in_brn;
    logic          in_j;
    logic          in_regw;
    logic          in_wai;
    logic          in_memw;
    logic          in_memr;
    logic          in_alusrc;
    logic [2:0]    in_aluop;

    logic          out_valid;
    logic [W-1:0]  out_alu;
    logic [W-1:0]  out_addr;
    logic [W-1:0]  out_wdata;
    logic [RW-1:0] out_rd;
    logic [W-1:0]  out_PC;
    logic          out_regw;
    logic          out_wai;
    logic          out_memw;
    logic          out_memr;
    logic          out_br_taken;
    logic [W-1:0]  out_br_target;
    logic          out_z;
    logic          out_n;

    modport master (
        output in_valid, in_imm, in_rd, in_rd1, in_rd2, in_PC,
        output in_brz, in_brn, in_j,
        output in_regw, in_wai, in_memw, in_memr,
        output in_alusrc, in_aluop,
        input  out_valid, out_alu, out_addr, out_wdata,
        input  out_rd, out_PC,
        input  out_regw, out_wai, out_memw, out_memr,
        input  out_br_taken, out_br_target, out_z, out_n
    );

    modport slave (
        input  in_valid, in_imm, in_rd, in_rd1, in_rd2, in_PC,
        input  in_brz, in_brn, in_j,
        input  in_regw, in_wai, in_memw, in_memr,
        input  in_alusrc, in_aluop,
        output out_valid, out_alu, out_addr, out_wdata,
        output out_rd, out_PC,
        output out_regw, out_wai, out_memw, out_memr,
        output out_br_taken, out_br_target, out_z, out_n
    );
endinterface

// File: rtl/stage3_alu.sv
// Combinational ALU of the execute stage.
// Unused opcodes produce zero; carries are dropped.
module stage3_alu
    import stage3_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [2:0]   i_aluop,
    output logic [W-1:0] o_result
);

    // Select the operation result
    always_comb begin
        o_result = '0;
        case (i_aluop)
            ALUOP_PASSA: o_result = i_a;
            ALUOP_ADD:   o_result = i_a + i_b;
            ALUOP_SUB:   o_result = i_a - i_b;
            ALUOP_NEG:   o_result = '0 - i_a;
            ALUOP_PASSB: o_result = i_b;
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/stage3.sv
// Execute stage: ALU, Z/N flags, branch resolve with
// squash of younger slots, and the EX/MEM register.
module stage3
    import stage3_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int RW     = DEF_RW,
    parameter int SQUASH = DEF_SQUASH
) (
    input logic     clk,
    input logic     rst,
    stage3_if.slave bus
);

    localparam int SQW = (SQUASH < 1) ? 1 : $clog2(SQUASH + 1);

    logic          w_ev;
    logic          w_taken;
    logic          w_flag_upd;
    logic [W-1:0]  w_b;
    logic [W-1:0]  w_alu;
    ctrl_t         w_ctrl;

    logic          r_valid;
    logic [W-1:0]  r_alu;
    logic [W-1:0]  r_addr;
    logic [W-1:0]  r_wdata;
    logic [RW-1:0] r_rd;
    logic [W-1:0]  r_pc;
    ctrl_t         r_ctrl;
    logic          r_br;
    logic [W-1:0]  r_tgt;
    logic          r_z;
    logic          r_n;
    logic [SQW-1:0] r_sq;

    stage3_alu #(.W(W)) u_alu (
        .i_a      (bus.in_rd1),
        .i_b      (w_b),
        .i_aluop  (bus.in_aluop),
        .o_result (w_alu)
    );

    // Slot qualification, operand mux and branch decision
    always_comb begin
        w_ev       = bus.in_valid & (r_sq == '0);
        w_b        = bus.in_alusrc ? bus.in_imm : bus.in_rd2;
        w_taken    = w_ev & (bus.in_j
                   | (bus.in_brz & r_z)
                   | (bus.in_brn & r_n));
        w_flag_upd = w_ev & bus.in_regw & ~bus.in_memr;
        w_ctrl     = '0;
        if (w_ev) begin
            w_ctrl.regw = bus.in_regw;
            w_ctrl.wai  = bus.in_wai;
            w_ctrl.memw = bus.in_memw;
            w_ctrl.memr = bus.in_memr;
        end
    end

    // Condition flags follow register-writing ALU results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z <= 1'b0;
            r_n <= 1'b0;
        end else if (w_flag_upd) begin
            r_z <= (w_alu == '0);
            r_n <= w_alu[W-1];
        end
    end

    // Squash counter: loaded on taken branch, counts dropped slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sq <= '0;
        end else if (w_taken) begin
            r_sq <= SQW'(SQUASH);
        end else if (bus.in_valid && r_sq != '0) begin
            r_sq <= r_sq - 1'b1;
        end
    end

    // Fetch redirect pulse and target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br  <= 1'b0;
            r_tgt <= '0;
        end else begin
            r_br <= w_taken;
            if (w_taken) begin
                r_tgt <= bus.in_rd1;
            end
        end
    end

    // EX/MEM register; data only advances for real slots
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_alu   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_pc    <= '0;
        end else begin
            r_valid <= w_ev;
            r_ctrl  <= w_ctrl;
            if (w_ev) begin
                r_alu   <= w_alu;
                r_addr  <= bus.in_rd1;
                r_wdata <= bus.in_rd2;
                r_rd    <= bus.in_rd;
                r_pc    <= bus.in_PC;
            end
        end
    end

    assign bus.out_valid     = r_valid;
    assign bus.out_alu       = r_alu;
    assign bus.out_addr      = r_addr;
    assign bus.out_wdata     = r_wdata;
    assign bus.out_rd        = r_rd;
    assign bus.out_PC        = r_pc;
    assign bus.out_regw      = r_ctrl.regw;
    assign bus.out_wai       = r_ctrl.wai;
    assign bus.out_memw      = r_ctrl.memw;
    assign bus.out_memr      = r_ctrl.memr;
    assign bus.out_br_taken  = r_br;
    assign bus.out_br_target = r_tgt;
    assign bus.out_z         = r_z;
    assign bus.out_n         = r_n;

endmodule

// File: tb/tb_stage3.sv
// Bench for the execute stage: scoreboard of expected
// EX/MEM contents plus directed scenario checks.
module tb_stage3;

    typedef struct {
        bit          v;
        logic [2:0]  op;
        bit          src;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;
        bit          regw;
        bit          wai;
        bit          memw;
        bit          memr;
        bit          brz;
        bit          brn;
        bit          j;
    } ins_t;

    typedef struct {
        bit          v;
        logic [31:0] alu;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [5:0]  rd;
        logic [31:0] pc;
        logic [3:0]  ctrl;
        bit          br;
        logic [31:0] tgt;
        bit          z;
        bit          n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    exp_t q[$];
    bit   m_z, m_n;
    int   m_sq;
    logic [31:0] m_pc = 32'h1000;

    stage3_if bus ();

    stage3 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(logic [2:0] op, logic [31:0] a,
                                logic [31:0] b);
        ins_t t;
        t = '{default: '0};
        t.v = 1'b1;
        t.op = op;
        t.a = a;
        t.b = b;
        t.rd = 6'd3;
        t.regw = 1'b1;
        return t;
    endfunction

    function automatic logic [31:0] ref_alu(ins_t t);
        logic [31:0] bb;
        bb = t.src ? t.imm : t.b;
        case (t.op)
            3'd0: return t.a;
            3'd1: return t.a + bb;
            3'd2: return t.a - bb;
            3'd3: return 32'd0 - t.a;
            3'd4: return bb;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_z = 0;
        m_n = 0;
        m_sq = 0;
        q.delete();
    endtask

    task automatic drive_idle();
        bus.in_valid = 0; bus.in_imm = 0; bus.in_rd = 0;
        bus.in_rd1 = 0; bus.in_rd2 = 0; bus.in_PC = 0;
        bus.in_brz = 0; bus.in_brn = 0; bus.in_j = 0;
        bus.in_regw = 0; bus.in_wai = 0; bus.in_memw = 0;
        bus.in_memr = 0; bus.in_alusrc = 0; bus.in_aluop = 0;
    endtask

    task automatic step(ins_t t);
        exp_t e;
        exp_t g;
        logic [31:0] res;
        bit ev;
        m_pc = m_pc + 4;
        bus.in_valid = t.v; bus.in_imm = t.imm; bus.in_rd = t.rd;
        bus.in_rd1 = t.a; bus.in_rd2 = t.b; bus.in_PC = m_pc;
        bus.in_brz = t.brz; bus.in_brn = t.brn; bus.in_j = t.j;
        bus.in_regw = t.regw; bus.in_wai = t.wai;
        bus.in_memw = t.memw; bus.in_memr = t.memr;
        bus.in_alusrc = t.src; bus.in_aluop = t.op;
        res = ref_alu(t);
        ev = t.v && (m_sq == 0);
        if (t.v && m_sq != 0) m_sq = m_sq - 1;
        e = '{default: '0};
        e.v = ev;
        e.alu = res;
        e.addr = t.a;
        e.wdata = t.b;
        e.rd = t.rd;
        e.pc = m_pc;
        e.ctrl = ev ? {t.regw, t.wai, t.memw, t.memr} : 4'd0;
        e.br = ev && (t.j || (t.brz && m_z) || (t.brn && m_n));
        e.tgt = t.a;
        if (ev && t.regw && !t.memr) begin
            m_z = (res == 0);
            m_n = res[31];
        end
        if (e.br) m_sq = 2;
        e.z = m_z;
        e.n = m_n;
        q.push_back(e);
        @(posedge clk);
        #1;
        drive_idle();
        g = q.pop_front();
        total++;
        if (bus.out_valid !== g.v) begin
            bad++;
            $display("FAIL valid: got %0b want %0b", bus.out_valid, g.v);
        end
        total++;
        if ({bus.out_regw, bus.out_wai, bus.out_memw, bus.out_memr}
            !== g.ctrl) begin
            bad++;
            $display("FAIL ctrl: got %b want %b",
                     {bus.out_regw, bus.out_wai, bus.out_memw,
                      bus.out_memr}, g.ctrl);
        end
        total++;
        if (bus.out_br_taken !== g.br) begin
            bad++;
            $display("FAIL br_taken: got %0b want %0b",
                     bus.out_br_taken, g.br);
        end
        total++;
        if ({bus.out_z, bus.out_n} !== {g.z, g.n}) begin
            bad++;
            $display("FAIL flags: got zn=%b%b want %b%b",
                     bus.out_z, bus.out_n, g.z, g.n);
        end
        if (g.br) begin
            total++;
            if (bus.out_br_target !== g.tgt) begin
                bad++;
                $display("FAIL target: got %h want %h",
                         bus.out_br_target, g.tgt);
            end
        end
        if (g.v) begin
            total++;
            if (bus.out_alu !== g.alu) begin
                bad++;
                $display("FAIL alu: got %h want %h", bus.out_alu, g.alu);
            end
            total++;
            if ({bus.out_addr, bus.out_wdata, bus.out_PC}
                !== {g.addr, g.wdata, g.pc}) begin
                bad++;
                $display("FAIL pass: got %h %h %h want %h %h %h",
                         bus.out_addr, bus.out_wdata, bus.out_PC,
                         g.addr, g.wdata, g.pc);
            end
            total++;
            if (bus.out_rd !== g.rd) begin
                bad++;
                $display("FAIL rd: got %0d want %0d", bus.out_rd, g.rd);
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1;
        model_reset();
        #12;
        total++;
        if ({bus.out_valid, bus.out_alu, bus.out_br_taken,
             bus.out_br_target, bus.out_z, bus.out_n, bus.out_regw,
             bus.out_memr, bus.out_PC} !== '0) begin
            bad++;
            $display("FAIL reset: outputs not zero alu=%h tgt=%h v=%b",
                     bus.out_alu, bus.out_br_target, bus.out_valid);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_add();
        step(mk(3'd1, 32'd5, 32'd7));
        total++;
        if (bus.out_alu !== 32'd12 || bus.out_valid !== 1'b1
            || bus.out_z !== 1'b0 || bus.out_n !== 1'b0) begin
            bad++;
            $display("FAIL add: got alu=%h v=%b z=%b n=%b want 12 1 0 0",
                     bus.out_alu, bus.out_valid, bus.out_z, bus.out_n);
        end
    endtask

    task automatic test_sub_brz();
        ins_t t;
        step(mk(3'd2, 32'd9, 32'd9));
        total++;
        if (bus.out_z !== 1'b1) begin
            bad++;
            $display("FAIL sub_z: got %b want 1", bus.out_z);
        end
        t = mk(3'd0, 32'h40, 32'd0);
        t.regw = 0;
        t.brz = 1;
        step(t);
        total++;
        if (bus.out_br_taken !== 1'b1 || bus.out_br_target !== 32'h40) begin
            bad++;
            $display("FAIL brz: got %b %h want 1 00000040",
                     bus.out_br_taken, bus.out_br_target);
        end
        t = '{default: '0};
        step(t);
        total++;
        if (bus.out_br_taken !== 1'b0) begin
            bad++;
            $display("FAIL br_pulse: got %b want 0", bus.out_br_taken);
        end
    endtask

    task automatic test_squash();
        ins_t t;
        for (int i = 0; i < 3; i++) begin
            t = mk(3'd1, 32'd1, 32'(i));
            t.memw = 1;
            step(t);
            total++;
            if (bus.out_valid !== (i == 2) || bus.out_memw !== (i == 2)) begin
                bad++;
                $display("FAIL squash%0d: got v=%b memw=%b want %b",
                         i, bus.out_valid, bus.out_memw, i == 2);
            end
        end
    endtask

    task automatic test_brn();
        ins_t t;
        step(mk(3'd1, 32'd1, 32'd2));
        t = mk(3'd0, 32'h80, 32'd0);
        t.regw = 0;
        t.brn = 1;
        step(t);
        total++;
        if (bus.out_br_taken !== 1'b0) begin
            bad++;
            $display("FAIL brn: got %b want 0", bus.out_br_taken);
        end
        step(mk(3'd4, 32'd0, 32'd77));
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'd77) begin
            bad++;
            $display("FAIL no_squash: got v=%b alu=%h want 1 77",
                     bus.out_valid, bus.out_alu);
        end
    endtask

    task automatic test_imm_neg();
        ins_t t;
        t = mk(3'd1, 32'd4, 32'd100);
        t.src = 1;
        t.imm = 32'hFFFF_FFFF;
        step(t);
        total++;
        if (bus.out_alu !== 32'd3) begin
            bad++;
            $display("FAIL imm: got %h want 3", bus.out_alu);
        end
        step(mk(3'd3, 32'd1, 32'd0));
        total++;
        if (bus.out_alu !== 32'hFFFF_FFFF || bus.out_n !== 1'b1) begin
            bad++;
            $display("FAIL neg: got %h n=%b want ffffffff 1",
                     bus.out_alu, bus.out_n);
        end
        t = mk(3'd6, 32'd5, 32'd5);
        t.memr = 1;
        step(t);
        total++;
        if (bus.out_alu !== 32'd0 || bus.out_n !== 1'b1
            || bus.out_z !== 1'b0) begin
            bad++;
            $display("FAIL load_hold: got alu=%h z=%b n=%b want 0 0 1",
                     bus.out_alu, bus.out_z, bus.out_n);
        end
    endtask

    task automatic test_rst_squash();
        ins_t t;
        t = mk(3'd0, 32'h100, 32'd0);
        t.regw = 0;
        t.j = 1;
        step(t);
        step(mk(3'd1, 32'd2, 32'd2));
        #2;
        rst = 1;
        #1;
        total++;
        if ({bus.out_valid, bus.out_alu, bus.out_br_taken,
             bus.out_br_target, bus.out_z, bus.out_n,
             bus.out_PC} !== '0) begin
            bad++;
            $display("FAIL async_rst: got tgt=%h n=%b alu=%h want 0",
                     bus.out_br_target, bus.out_n, bus.out_alu);
        end
        #1;
        rst = 0;
        model_reset();
        step(mk(3'd1, 32'd20, 32'd22));
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_alu !== 32'd42) begin
            bad++;
            $display("FAIL post_rst: got v=%b alu=%h want 1 2a",
                     bus.out_valid, bus.out_alu);
        end
    endtask

    task automatic test_back_to_back();
        ins_t t;
        for (int i = 0; i < 40; i++) begin
            t = mk(3'($urandom_range(0, 7)), $urandom, $urandom);
            t.v = ($urandom_range(0, 3) != 0);
            t.src = $urandom_range(0, 1);
            t.imm = $urandom;
            t.rd = 6'($urandom);
            t.regw = $urandom_range(0, 1);
            t.memr = $urandom_range(0, 1);
            t.wai = $urandom_range(0, 1);
            t.brz = ($urandom_range(0, 5) == 0);
            t.brn = ($urandom_range(0, 5) == 0);
            t.j = ($urandom_range(0, 9) == 0);
            step(t);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_brz();
        test_squash();
        test_brn();
        test_imm_neg();
        test_rst_squash();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
